// File: rtl/prco_fetch_unit.sv
// Fetch stage in front of prco_lmem: PC, single-outstanding fetch, instruction queue, data-port arbitration.
// Optional PC bounds fault enabled by defining PRCO_FETCH_BOUNDS_EN.
module prco_fetch_unit #(
   parameter logic [15:0] P_RESET_PC    = 16'h0000,
   parameter int          P_QUEUE_DEPTH = 2,
   parameter logic [15:0] P_PC_MAX      = 16'h00FF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        q_ce_fetch,
   output logic [15:0] q_mem_addr,
   input  logic        i_ce_dec,
   input  logic [15:0] i_mem_douta,
   input  logic        i_dmem_req,
   output logic        q_dmem_grant,
   input  logic        i_branch_en,
   input  logic [15:0] i_branch_addr,
   output logic [15:0] q_instr,
   output logic [15:0] q_instr_pc,
   output logic        q_instr_valid,
   input  logic        i_instr_ready,
   output logic        q_fetch_fault,
   output logic        o_dbg_state
);

   localparam int LP_AW = (P_QUEUE_DEPTH > 1) ? $clog2(P_QUEUE_DEPTH) : 1;
   localparam int LP_CW = LP_AW + 1;
   localparam logic [LP_CW-1:0] LP_DEPTH = LP_CW'(P_QUEUE_DEPTH);

   typedef enum logic {S_ISSUE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_pc;
   logic              r_discard;
   logic              r_ce_fetch;
   logic [15:0]       r_mem_addr;
   logic              r_dmem_grant;
   logic              r_fault;
   logic [15:0]       r_q_instr [P_QUEUE_DEPTH];
   logic [15:0]       r_q_pc    [P_QUEUE_DEPTH];
   logic [LP_AW-1:0]  r_rd;
   logic [LP_AW-1:0]  r_wr;
   logic [LP_CW-1:0]  r_count;

   logic              w_room;
   logic              w_bounds_hit;
   logic              w_halted;
   logic              w_issue_ok;
   logic              w_head_valid;
   logic              w_pop;
   logic              w_flush;
   logic              w_issue;
   logic              w_grant;
   logic              w_push;
   logic              w_fault_set;
   logic              w_discard_nxt;
   logic [15:0]       w_pc_nxt;

`ifdef PRCO_FETCH_BOUNDS_EN
   assign w_bounds_hit = (r_pc > P_PC_MAX);
   assign w_halted     = r_fault;
`else
   logic w_unused_pc_max;
   assign w_bounds_hit    = 1'b0;
   assign w_halted        = 1'b0;
   assign w_unused_pc_max = ^P_PC_MAX;
`endif

   // Queue handshake: the head transfers on a cycle where q_instr_valid and i_instr_ready are both 1;
   // a branch in that cycle flushes instead, so the head is not consumed.
   assign w_head_valid = (r_count != '0);
   assign w_pop        = w_head_valid && i_instr_ready && !i_branch_en;
   assign w_flush      = i_branch_en;
   assign w_room       = (r_count < LP_DEPTH);
   assign w_issue_ok   = !i_branch_en && !i_dmem_req && w_room && !w_halted && !w_bounds_hit;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_ISSUE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ISSUE: if (w_issue_ok) w_state_nxt = S_WAIT;
         S_WAIT:  if (i_ce_dec)   w_state_nxt = S_ISSUE;
         default: w_state_nxt = S_ISSUE;
      endcase
   end

   always_comb begin
      w_issue       = 1'b0;
      w_grant       = 1'b0;
      w_push        = 1'b0;
      w_fault_set   = 1'b0;
      w_discard_nxt = r_discard;
      w_pc_nxt      = r_pc;
      case (r_state)
         S_ISSUE: begin
            if (i_branch_en)      w_pc_nxt = i_branch_addr;
            else if (i_dmem_req)  w_grant  = 1'b1;
            else if (w_room && !w_halted) begin
               if (w_bounds_hit)  w_fault_set = 1'b1;
               else               w_issue     = 1'b1;
            end
         end
         S_WAIT: begin
            // A redirect while a fetch is in flight marks its word for dropping unless it lands now.
            if (i_branch_en) begin
               w_pc_nxt      = i_branch_addr;
               w_discard_nxt = !i_ce_dec;
            end else if (i_ce_dec) begin
               if (r_discard) begin
                  w_discard_nxt = 1'b0;
               end else begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + 16'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc         <= P_RESET_PC;
         r_discard    <= 1'b0;
         r_ce_fetch   <= 1'b0;
         r_mem_addr   <= P_RESET_PC;
         r_dmem_grant <= 1'b0;
         r_fault      <= 1'b0;
         r_rd         <= '0;
         r_wr         <= '0;
         r_count      <= '0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_discard    <= w_discard_nxt;
         r_ce_fetch   <= w_issue;
         r_dmem_grant <= w_grant;
         if (w_issue)     r_mem_addr <= r_pc;
         if (w_fault_set) r_fault    <= 1'b1;
         if (w_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + LP_AW'(1);
            if (w_pop)  r_rd <= r_rd + LP_AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + LP_CW'(1);
               2'b01:   r_count <= r_count - LP_CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_q_instr[r_wr] <= i_mem_douta;
         r_q_pc[r_wr]    <= r_pc;
      end
   end

   assign q_ce_fetch    = r_ce_fetch;
   assign q_mem_addr    = r_mem_addr;
   assign q_dmem_grant  = r_dmem_grant;
   assign q_fetch_fault = r_fault;
   assign q_instr_valid = w_head_valid;
   assign q_instr       = w_head_valid ? r_q_instr[r_rd] : 16'h0000;
   assign q_instr_pc    = w_head_valid ? r_q_pc[r_rd]    : 16'h0000;
   assign o_dbg_state   = (r_state == S_WAIT);

endmodule
